// File: rtl/seven_seg_pkg.sv
// Shared mode encoding for the seven-segment animator.
// Also used by top-level LED decode of the active mode.
package seven_seg_pkg;

    typedef enum logic [2:0] {
        MODE_COUNT   = 3'd0,
        MODE_MANUAL  = 3'd1,
        MODE_SCROLL  = 3'd2,
        MODE_PATTERN = 3'd3,
        MODE_HOLD    = 3'd4
    } mode_t;

    localparam logic [2:0] MODE_ENC_COUNT   = 3'(MODE_COUNT);
    localparam logic [2:0] MODE_ENC_MANUAL  = 3'(MODE_MANUAL);
    localparam logic [2:0] MODE_ENC_SCROLL  = 3'(MODE_SCROLL);
    localparam logic [2:0] MODE_ENC_PATTERN = 3'(MODE_PATTERN);
    localparam logic [2:0] MODE_ENC_HOLD    = 3'(MODE_HOLD);

endpackage

// File: rtl/seven_seg_tick_gen.sv
// Animation tick source: free-running divider or single-step.
// tick is a registered one-cycle pulse.
module seven_seg_tick_gen #(
    parameter int DIV_MAX = 4_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic step,
    output logic tick
);

    localparam int CW = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    logic [CW-1:0] cnt;
    logic          step_d;

    // Divider counts while running; paused mode ticks on step rise.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt    <= '0;
            tick   <= 1'b0;
            step_d <= 1'b0;
        end else begin
            step_d <= step;
            tick   <= 1'b0;
            if (run) begin
                if (cnt == CW'(DIV_MAX - 1)) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (step && !step_d) begin
                tick <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_animator.sv
// Content generator for the multiplexed seven-segment driver.
// Define SEVEN_SEG_ANIM_BCD_EN for a decimal-per-digit counter.
module seven_segment_animator
    import seven_seg_pkg::*;
#(
    parameter int                  W_DIGITS = 8,
    parameter int                  DIV_MAX  = 4_000_000,
    parameter logic [4*W_DIGITS-1:0] PATTERN = 32'hDEAD_BEEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [2:0]                  mode,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        step,
    input  logic                        edit,
    input  logic                        cursor_next,
    input  logic [3:0]                  nibble,
    input  logic [W_DIGITS-1:0]         dots_mask,
    output logic [4*W_DIGITS-1:0]       number,
    output logic [W_DIGITS-1:0]         dots,
    output logic [$clog2(W_DIGITS)-1:0] cursor,
    output logic                        tick
);

    localparam int W_NUM = 4 * W_DIGITS;
    localparam int W_CUR = $clog2(W_DIGITS);
    localparam logic [W_CUR-1:0] LAST = W_CUR'(W_DIGITS - 1);

    logic [2:0]          prev_mode;
    logic [W_CUR-1:0]    pos, pos_n, cursor_n;
    logic                bounce, bounce_n;
    logic                blink, blink_n;
    logic                edit_d, cn_d;
    logic                edit_rise, cn_rise;
    logic [W_NUM-1:0]    number_n;
    logic [W_DIGITS-1:0] dots_n;

`ifdef SEVEN_SEG_ANIM_BCD_EN
    function automatic logic [W_NUM-1:0] count_next(
        input logic [W_NUM-1:0] v,
        input logic             down
    );
        logic [W_NUM-1:0] r;
        logic             c;
        logic [3:0]       d;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < W_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (d > 4'd9) d = 4'd0;
            if (c) begin
                if (!down) begin
                    if (d == 4'd9) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = 4'd9;
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction
`else
    function automatic logic [W_NUM-1:0] count_next(
        input logic [W_NUM-1:0] v,
        input logic             down
    );
        return down ? v - 1'b1 : v + 1'b1;
    endfunction
`endif

    seven_seg_tick_gen #(
        .DIV_MAX (DIV_MAX)
    ) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .step    (step),
        .tick    (tick)
    );

    assign edit_rise = edit && !edit_d;
    assign cn_rise   = cursor_next && !cn_d;

    // Next content: mode entry first, otherwise one animation step.
    always_comb begin
        number_n = number;
        cursor_n = cursor;
        pos_n    = pos;
        bounce_n = bounce;
        blink_n  = blink;
        if (mode != prev_mode) begin
            if (mode == MODE_ENC_SCROLL) begin
                pos_n    = '0;
                bounce_n = 1'b0;
                number_n = W_NUM'(4'hF);
            end
            if (mode == MODE_ENC_PATTERN) number_n = PATTERN;
        end else begin
            case (mode)
                MODE_ENC_COUNT: begin
                    if (tick) number_n = count_next(number, dir);
                end
                MODE_ENC_MANUAL: begin
                    if (tick) blink_n = ~blink;
                    if (edit_rise) number_n[{cursor, 2'b00} +: 4] = nibble;
                    if (cn_rise) cursor_n = (cursor == LAST) ? '0 : cursor + 1'b1;
                end
                MODE_ENC_SCROLL: begin
                    if (tick) begin
                        if (!dir) begin
                            pos_n = (pos == LAST) ? '0 : pos + 1'b1;
                        end else if (!bounce) begin
                            if (pos == LAST) begin
                                bounce_n = 1'b1;
                                pos_n    = pos - 1'b1;
                            end else begin
                                pos_n = pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                bounce_n = 1'b0;
                                pos_n    = pos + 1'b1;
                            end else begin
                                pos_n = pos - 1'b1;
                            end
                        end
                        number_n = W_NUM'(4'hF) << {pos_n, 2'b00};
                    end
                end
                MODE_ENC_PATTERN: begin
                    if (tick) number_n = {number[W_NUM-5:0], number[W_NUM-1 -: 4]};
                end
                default: ;
            endcase
        end
        dots_n = dots_mask;
        if (mode == MODE_ENC_MANUAL && blink) dots_n = dots_mask ^ (W_DIGITS'(1) << cursor);
    end

    // State register; reset aborts any animation in progress.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            number    <= '0;
            dots      <= '0;
            cursor    <= '0;
            pos       <= '0;
            bounce    <= 1'b0;
            blink     <= 1'b0;
            edit_d    <= 1'b0;
            cn_d      <= 1'b0;
            prev_mode <= MODE_ENC_COUNT;
        end else begin
            number    <= number_n;
            dots      <= dots_n;
            cursor    <= cursor_n;
            pos       <= pos_n;
            bounce    <= bounce_n;
            blink     <= blink_n;
            edit_d    <= edit;
            cn_d      <= cursor_next;
            prev_mode <= mode;
        end
    end

endmodule

// File: tb/tb_seven_segment_animator.sv
// Bench for seven_segment_animator: digit-level model plus literals.
// W_DIGITS=8, DIV_MAX=4.
module tb_seven_segment_animator;
    import seven_seg_pkg::*;

    localparam int WD  = 8;
    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        step = 1'b0;
    logic        edit = 1'b0;
    logic        cursor_next = 1'b0;
    logic [3:0]  nibble = 4'd0;
    logic [7:0]  dots_mask = 8'd0;
    logic [31:0] number;
    logic [7:0]  dots;
    logic [2:0]  cursor;
    logic        tick;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seven_segment_animator #(
        .W_DIGITS (WD),
        .DIV_MAX  (DIV),
        .PATTERN  (32'hDEAD_BEEF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mode        (mode),
        .run         (run),
        .dir         (dir),
        .step        (step),
        .edit        (edit),
        .cursor_next (cursor_next),
        .nibble      (nibble),
        .dots_mask   (dots_mask),
        .number      (number),
        .dots        (dots),
        .cursor      (cursor),
        .tick        (tick)
    );

    // Model: digits as integers, positions as signed ints.
    int         m_dig[WD];
    int         m_cursor, m_pos, m_vel, m_div, m_prev;
    bit         m_blink, m_tick, m_step_d, m_edit_d, m_cn_d;
    logic [7:0] m_dots;
    bit         m_live = 1'b0;

    function automatic logic [31:0] pack_dig();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < WD; i++) r[4*i +: 4] = 4'(m_dig[i]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin : model
        bit          er, cr, sr, ot;
        int          old[WD];
        logic [31:0] v;
        longint      val;
        if (!reset_n) begin
            foreach (m_dig[i]) m_dig[i] = 0;
            m_cursor = 0; m_pos = 0; m_vel = 1; m_div = 0; m_prev = 0;
            m_blink = 0; m_tick = 0; m_step_d = 0; m_edit_d = 0; m_cn_d = 0;
            m_dots = 8'h00;
            m_live = 1'b1;
        end else begin
            er = edit && !m_edit_d;
            cr = cursor_next && !m_cn_d;
            sr = step && !m_step_d;
            ot = m_tick;
            m_dots = dots_mask;
            if (mode == 3'd1 && m_blink) m_dots = dots_mask ^ 8'(1 << m_cursor);
            if (int'(mode) != m_prev) begin
                m_prev = int'(mode);
                if (mode == 3'd2) begin
                    m_pos = 0; m_vel = 1;
                    foreach (m_dig[i]) m_dig[i] = (i == 0) ? 15 : 0;
                end
                if (mode == 3'd3) begin
                    v = 32'hDEAD_BEEF;
                    foreach (m_dig[i]) m_dig[i] = int'(v[4*i +: 4]);
                end
            end else if (mode == 3'd0 && ot) begin
`ifdef SEVEN_SEG_ANIM_BCD_EN
                val = 0;
                for (int i = WD - 1; i >= 0; i--)
                    val = val * 10 + ((m_dig[i] > 9) ? 0 : m_dig[i]);
                val = dir ? (val + 64'd99999999) % 64'd100000000
                          : (val + 1) % 64'd100000000;
                foreach (m_dig[i]) begin
                    m_dig[i] = int'(val % 10);
                    val = val / 10;
                end
`else
                v = pack_dig();
                v = dir ? v - 32'd1 : v + 32'd1;
                foreach (m_dig[i]) m_dig[i] = int'(v[4*i +: 4]);
`endif
            end else if (mode == 3'd1) begin
                if (ot) m_blink = !m_blink;
                if (er) m_dig[m_cursor] = int'(nibble);
                if (cr) m_cursor = (m_cursor + 1) % WD;
            end else if (mode == 3'd2 && ot) begin
                if (!dir) m_pos = (m_pos + 1) % WD;
                else begin
                    if (m_pos + m_vel < 0 || m_pos + m_vel > WD - 1) m_vel = -m_vel;
                    m_pos = m_pos + m_vel;
                end
                foreach (m_dig[i]) m_dig[i] = (i == m_pos) ? 15 : 0;
            end else if (mode == 3'd3 && ot) begin
                old = m_dig;
                foreach (m_dig[i]) m_dig[i] = old[(i + WD - 1) % WD];
            end
            if (run) begin
                m_tick = (m_div == DIV - 1);
                m_div = (m_div + 1) % DIV;
            end else begin
                m_tick = sr;
            end
            m_step_d = step; m_edit_d = edit; m_cn_d = cursor_next;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (m_live) begin
            chk("model_number", number, pack_dig());
            chk("model_dots", {24'd0, dots}, {24'd0, m_dots});
            chk("model_cursor", {29'd0, cursor}, 32'(m_cursor));
            chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tick_and_settle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * DIV + 2; i++) begin
            @(negedge clock);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tick_wait actual=none required=pulse");
        end
        @(negedge clock);
    endtask

    task automatic pulse_cn();
        cursor_next = 1'b1;
        cyc(1);
        cursor_next = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
    endtask

    int seq_b[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int seq_w[7]  = '{2, 3, 4, 5, 6, 7, 0};

    initial begin
        cyc(3);
        chk("rst_number", number, 32'h0);
        chk("rst_dots", {24'd0, dots}, 32'h0);
        chk("rst_cursor", {29'd0, cursor}, 32'h0);
        chk("rst_tick", {31'd0, tick}, 32'h0);

        mode = MODE_ENC_COUNT; run = 1'b1; dir = 1'b0;
        reset_n = 1'b1;
        cyc(3);
        chk("tick_early", {31'd0, tick}, 32'h0);
        cyc(1);
        chk("tick_first", {31'd0, tick}, 32'h1);
        cyc(1);
        chk("count_1", number, 32'h1);
        tick_and_settle();
        chk("count_2", number, 32'h2);
        tick_and_settle();
        chk("count_3", number, 32'h3);
        reset_n = 1'b0;
        cyc(1);
        chk("rst_mid", number, 32'h0);
        reset_n = 1'b1;

        dir = 1'b1;
        tick_and_settle();
`ifdef SEVEN_SEG_ANIM_BCD_EN
        chk("count_down_wrap", number, 32'h9999_9999);
`else
        chk("count_down_wrap", number, 32'hFFFF_FFFF);
`endif

        run = 1'b0; dir = 1'b0;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        mode = MODE_ENC_MANUAL;
        dots_mask = 8'h3C;
        cyc(2);
        nibble = 4'hA; edit = 1'b1;
        cyc(1);
        edit = 1'b0;
        cyc(1);
        chk("man_edit", {28'd0, number[3:0]}, 32'hA);
        nibble = 4'h5; edit = 1'b1; cursor_next = 1'b1;
        cyc(1);
        edit = 1'b0; cursor_next = 1'b0;
        cyc(1);
        chk("man_both_d0", {28'd0, number[3:0]}, 32'h5);
        chk("man_both_cur", {29'd0, cursor}, 32'h1);
        repeat (7) pulse_cn();
        chk("cur_wrap7", {29'd0, cursor}, 32'h0);
        repeat (8) pulse_cn();
        chk("cur_wrap8", {29'd0, cursor}, 32'h0);
        repeat (3) pulse_cn();
        nibble = 4'h7; edit = 1'b1;
        cyc(1);
        edit = 1'b0;
        cyc(1);
        chk("man_d3", number, 32'h0000_7005);
        chk("man_dots_noblink", {24'd0, dots}, 32'h3C);
        run = 1'b1;
        cyc(20);

`ifdef SEVEN_SEG_ANIM_BCD_EN
        run = 1'b0;
        do_reset();
        mode = MODE_ENC_MANUAL;
        cyc(2);
        nibble = 4'h9; edit = 1'b1;
        cyc(1);
        edit = 1'b0;
        mode = MODE_ENC_COUNT;
        cyc(3);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        chk("bcd_carry", number, 32'h0000_0010);
`endif

        run = 1'b1; dir = 1'b1; dots_mask = 8'hA5;
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        mode = MODE_ENC_SCROLL;
        cyc(2);
        chk("scroll_entry", number, 32'h0000_000F);
        foreach (seq_b[i]) begin
            tick_and_settle();
            chk("scroll_bounce", number, 32'hF << (4 * seq_b[i]));
        end
        dir = 1'b0;
        foreach (seq_w[i]) begin
            tick_and_settle();
            chk("scroll_wrap", number, 32'hF << (4 * seq_w[i]));
        end
        chk("scroll_dots", {24'd0, dots}, 32'hA5);

        mode = MODE_ENC_PATTERN;
        cyc(1);
        chk("pat_entry", number, 32'hDEAD_BEEF);
        tick_and_settle();
        chk("pat_rot1", number, 32'hEADB_EEFD);
        run = 1'b0;
        cyc(10);
        chk("pat_paused", number, 32'hEADB_EEFD);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
        chk("pat_step", number, 32'hADBE_EFDE);
        cyc(5);
        chk("pat_step_once", number, 32'hADBE_EFDE);

        mode = 3'd5; run = 1'b1;
        cyc(20);
        chk("hold_number", number, 32'hADBE_EFDE);
        chk("hold_dots", {24'd0, dots}, 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
